// File: rtl/uc_pkg.sv
// Shared encodings for the uc_seq control-unit sequencer.
// Instruction classes, FSM states, MXRB selects and uc_W_RF strobe bit indices.
package uc_pkg;

    typedef enum logic [2:0] {
        CLS_ALU    = 3'd0,
        CLS_LOAD   = 3'd1,
        CLS_STORE  = 3'd2,
        CLS_JAL    = 3'd3,
        CLS_BRANCH = 3'd4,
        CLS_NOP    = 3'd5,
        CLS_HALT   = 3'd6,
        CLS_ILL    = 3'd7
    } cls_t;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [1:0] MXRB_ALU = 2'b00;
    localparam logic [1:0] MXRB_DM  = 2'b01;
    localparam logic [1:0] MXRB_PC  = 2'b10;

    localparam int RF_RD    = 0;
    localparam int RF_FLAGS = 1;
    localparam int RF_LINK  = 2;

    // Classes that write the PC themselves in EXEC (no PC+4 advance).
    function automatic logic is_pc_ctl(input cls_t c);
        return (c == CLS_JAL) || (c == CLS_BRANCH);
    endfunction

    // Classes that access data memory.
    function automatic logic is_mem(input cls_t c);
        return (c == CLS_LOAD) || (c == CLS_STORE);
    endfunction

endpackage

// File: rtl/uc_seq.sv
// Multicycle control-unit sequencer: FETCH/DECODE/EXEC/MEM/WB/HALT Moore FSM.
// Optional macro UC_SEQ_WB_SKIP_EN lets STORE, BRANCH and NOP bypass WB.
module uc_seq
    import uc_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [2:0] inst_class,
    output logic       uc_W_PC,
    output logic       uc_W_IR,
    output logic       uc_W_DM,
    output logic [1:0] uc_S_MXRB,
    output logic [2:0] uc_W_RF,
    output logic       halted
);

    localparam logic [2:0] MEM_INIT = 3'(MEM_LAT - 1);

    state_t     state;
    state_t     state_nx;
    cls_t       cls;
    cls_t       cls_nx;
    cls_t       cls_in;
    logic [2:0] mem_cnt;
    logic [2:0] cnt_nx;
    logic       armed;

    assign cls_in = cls_t'(inst_class);

    // armed holds FETCH across the first edge after reset release,
    // so the first real FETCH cycle follows that edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
        end
    end

    // State, latched class and memory-latency counter.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= ST_FETCH;
            cls     <= CLS_NOP;
            mem_cnt <= 3'd0;
        end else begin
            state   <= state_nx;
            cls     <= cls_nx;
            mem_cnt <= cnt_nx;
        end
    end

    // Next-state and Moore output decode from state and latched class.
    always_comb begin
        state_nx  = state;
        cls_nx    = cls;
        cnt_nx    = mem_cnt;
        uc_W_PC   = 1'b0;
        uc_W_IR   = 1'b0;
        uc_W_DM   = 1'b0;
        uc_S_MXRB = MXRB_ALU;
        uc_W_RF   = 3'b000;
        halted    = 1'b0;
        unique case (state)
            ST_FETCH: begin
                uc_W_IR = 1'b1;
                if (armed) begin
                    state_nx = ST_DECODE;
                end
            end
            ST_DECODE: begin
                cls_nx = (cls_in == CLS_ILL) ? CLS_NOP : cls_in;
                if (cls_in == CLS_HALT) begin
                    state_nx = ST_HALT;
                end else begin
                    state_nx = ST_EXEC;
                end
            end
            ST_EXEC: begin
                uc_W_PC = is_pc_ctl(cls);
                if (is_mem(cls)) begin
                    state_nx = ST_MEM;
                    cnt_nx   = MEM_INIT;
                end else begin
                    state_nx = ST_WB;
`ifdef UC_SEQ_WB_SKIP_EN
                    if (cls == CLS_BRANCH) begin
                        state_nx = ST_FETCH;
                    end else if (cls == CLS_NOP) begin
                        state_nx = ST_FETCH;
                        uc_W_PC  = 1'b1;
                    end
`endif
                end
            end
            ST_MEM: begin
                uc_W_DM = (cls == CLS_STORE);
                if (mem_cnt == 3'd0) begin
                    state_nx = ST_WB;
`ifdef UC_SEQ_WB_SKIP_EN
                    if (cls == CLS_STORE) begin
                        state_nx = ST_FETCH;
                        uc_W_PC  = 1'b1;
                    end
`endif
                end else begin
                    cnt_nx = mem_cnt - 3'd1;
                end
            end
            ST_WB: begin
                state_nx = ST_FETCH;
                uc_W_PC  = !is_pc_ctl(cls);
                case (cls)
                    CLS_ALU: begin
                        uc_S_MXRB          = MXRB_ALU;
                        uc_W_RF[RF_RD]     = 1'b1;
                        uc_W_RF[RF_FLAGS]  = 1'b1;
                    end
                    CLS_LOAD: begin
                        uc_S_MXRB      = MXRB_DM;
                        uc_W_RF[RF_RD] = 1'b1;
                    end
                    CLS_JAL: begin
                        uc_S_MXRB        = MXRB_PC;
                        uc_W_RF[RF_LINK] = 1'b1;
                    end
                    default: begin
                        uc_S_MXRB = MXRB_ALU;
                        uc_W_RF   = 3'b000;
                    end
                endcase
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_nx = ST_FETCH;
            end
        endcase
    end

endmodule

// File: doc/uc_seq.md
# uc_seq

Multicycle control-unit sequencer for the processor datapath. It steps each instruction through FETCH, DECODE, EXEC, optional MEM and WB, and drives the stage enables. It also drives the writeback-stage controls: the MXRB source select (`uc_S_MXRB`) and the register-file/flag write strobes (`uc_W_RF`). It sits between the instruction decoder and the IF/EX/MEM/WB stages.

## Interface
Parameters:
- `MEM_LAT`, default 1: data-memory access cycles spent in MEM; legal range 1..7.

Ports:
- `CLK`  in  1  system clock, rising edge.
- `RST`  in  1  asynchronous reset, active-low.
- `inst_class`  in  3  decoder class of the instruction in IR, sampled in DECODE:
  - 0 ALU
  - 1 LOAD
  - 2 STORE
  - 3 JAL (jump and link)
  - 4 BRANCH
  - 5 NOP
  - 6 HALT
  - 7 illegal, treated as NOP
- `uc_W_PC`  out  1  PC register write enable.
- `uc_W_IR`  out  1  IR load enable.
- `uc_W_DM`  out  1  data-memory write enable.
- `uc_S_MXRB`  out  2  writeback mux select:
  - 00 `alu_result`
  - 01 `dm_Q`
  - 10 `mxpc_out`
  - 11 reserved, never driven
- `uc_W_RF`  out  3  writeback strobes:
  - [0] destination register write
  - [1] O/S/C/Z flag write
  - [2] link-register write
- `halted`  out  1  high while in HALT.

## Operation
- Moore FSM. State register plus 3-bit `mem_cnt`. All outputs are decoded from state and the latched class only, never from live `inst_class`.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- Transitions:
  - FETCH → DECODE, always.
  - DECODE → EXEC, always. Latches `inst_class` into `cls`. If the class is HALT, DECODE → HALT instead.
  - EXEC → MEM when `cls` is LOAD or STORE; `mem_cnt` loads `MEM_LAT-1`.
  - EXEC → WB for any other class.
  - MEM → WB when `mem_cnt`==0; otherwise stay in MEM and decrement.
  - WB → FETCH, always.
  - HALT is absorbing; only `RST` leaves it.
- Outputs per state (anything not listed is 0):
  - FETCH: `uc_W_IR`=1.
  - EXEC: `uc_W_PC`=1 when `cls` is JAL or BRANCH. Next-PC selection itself is outside this block.
  - MEM: `uc_W_DM`=1 on every MEM cycle when `cls`=STORE.
  - WB, ALU: `uc_S_MXRB`=00, `uc_W_RF`=3'b011.
  - WB, LOAD: `uc_S_MXRB`=01, `uc_W_RF`=3'b001.
  - WB, JAL: `uc_S_MXRB`=10, `uc_W_RF`=3'b100.
  - WB, STORE/BRANCH/NOP: `uc_S_MXRB`=00, `uc_W_RF`=000.
  - WB, every class: `uc_W_PC`=1 (PC+4 advance) unless `cls` is JAL or BRANCH.
  - HALT: `halted`=1.
- Reset state: FETCH, `cls`=NOP, `mem_cnt`=0. Outputs at reset: `uc_W_IR`=1, all others 0.

## Timing
- Registered state. Outputs change only after a rising `CLK` or an asynchronous `RST` assertion.
- Cycles per instruction:
  - ALU, JAL, BRANCH, NOP: 4.
  - LOAD, STORE: 4+`MEM_LAT`.
  - HALT: 2 cycles to reach HALT.
- `uc_W_RF` is a one-cycle pulse and is never asserted outside WB. `dm_Q` must be valid by the WB edge.
- `inst_class` is sampled only in DECODE. Changes in any other state are ignored.
- `RST` low mid-instruction (including mid-MEM): immediate return to FETCH. No pending `uc_W_RF` or `uc_W_DM` strobe survives. Outputs are back at reset values within the same cycle.
- `RST` deasserting: the first FETCH cycle is the cycle after the first rising `CLK` with `RST` high.

## Configuration
- `UC_SEQ_WB_SKIP_EN` defined: STORE, BRANCH and NOP skip WB.
  - EXEC → FETCH for BRANCH/NOP; the final MEM cycle → FETCH for STORE.
  - The PC+4 `uc_W_PC` moves into EXEC for NOP, and into the final MEM cycle for STORE.
  - CPI: NOP 3, STORE 3+`MEM_LAT`, BRANCH 3 (its EXEC `uc_W_PC` already covers it).
- Not defined: every class passes through WB exactly as in Operation.

## Structure
- Shared package `uc_pkg`:
  - `inst_class` encodings.
  - State encodings.
  - MXRB select constants (`MXRB_ALU`, `MXRB_DM`, `MXRB_PC`).
  - `uc_W_RF` bit indices.
- Single module, no sub-modules. The output decode stays in the same file as the FSM.

## Test plan
- Reset, then ALU class presented in DECODE → `uc_W_RF`=011 and `uc_S_MXRB`=00 exactly on cycle 4; `uc_W_IR` pulses on cycles 1 and 5.
- LOAD with `MEM_LAT`=3 → 3 MEM cycles; WB on cycle 7 with `uc_S_MXRB`=01 and `uc_W_RF`=001.
- STORE with `MEM_LAT`=2 → `uc_W_DM`=1 for exactly 2 cycles; `uc_W_RF` stays 000. With `UC_SEQ_WB_SKIP_EN` defined, FETCH follows immediately.
- JAL → `uc_W_PC`=1 in EXEC; WB gives `uc_S_MXRB`=10 and `uc_W_RF`=100, with no second `uc_W_PC`.
- `RST` pulsed low during the second MEM cycle of a STORE → `uc_W_DM` drops immediately; FETCH outputs (`uc_W_IR`=1, all others 0) appear with no clock edge.
- HALT class → `halted`=1 from cycle 3 and stays high for 20 cycles while `inst_class` toggles; cleared only by `RST`.
